// File: rtl/disp_scan_ctrl_pkg.sv
// Types, constants and helpers for the scanned 4-digit display controller.
package disp_scan_ctrl_pkg;
`include "disp_defs.vh"

    localparam logic [3:0] BLANK_RST = `DISP_BLANK_RST;
    localparam logic [1:0] SCAN_LAST = `DISP_SCAN_LAST;

    typedef enum logic {StIdle, StPend} upd_state_e;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  point;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic        lzs;
    } disp_cfg_t;

    // Digit i (i>=1) is a leading zero when it and every digit above it are zero.
    function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic en);
        logic [3:0] m;
        m[3] = en && (d[15:12] == 4'h0);
        m[2] = m[3] && (d[11:8] == 4'h0);
        m[1] = m[2] && (d[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction
endpackage

// File: rtl/disp_clkdiv.sv
// Free-running scan divider; tick marks the last cycle of each digit slot.
module disp_clkdiv #(
    parameter int unsigned DIV_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = &div_cnt;
endmodule

// File: rtl/disp_defs.vh
// Shared display defines: reset values and scan limits common to display blocks.
`ifndef DISP_DEFS_VH
`define DISP_DEFS_VH
`define DISP_BLANK_RST 4'hF
`define DISP_SCAN_LAST 2'b11
`endif

// File: rtl/disp_scan_ctrl.sv
// Scanned 4-digit display controller; updates are double-buffered to frame boundaries.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W   = 17,
    parameter int unsigned BLINK_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_point,
    input  logic [3:0]  wr_blank,
    input  logic [3:0]  wr_blink,
    input  logic        wr_lzs,
    output logic        busy,
    output logic        upd_done,
    output logic [1:0]  Scan,
    output logic [15:0] Hexs,
    output logic [3:0]  point,
    output logic [3:0]  LES
);
    logic               tick;
    logic               frame_end;
    logic               commit;
    upd_state_e         state_q, state_d;
    disp_cfg_t          shadow_q, shadow_d;
    disp_cfg_t          wr_cfg, commit_cfg;
    logic [3:0]         blank_q;
    logic [3:0]         blink_q;
    logic               lzs_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               phase;

    disp_clkdiv #(
        .DIV_W(DIV_W)
    ) u_clkdiv (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign frame_end = tick && (Scan == SCAN_LAST);
    assign wr_cfg    = '{data: wr_data, point: wr_point, blank: wr_blank,
                         blink: wr_blink, lzs: wr_lzs};

    // A write landing on frame_end bypasses the shadow and commits directly.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        commit     = 1'b0;
        commit_cfg = shadow_q;
        if (frame_end) begin
            state_d = StIdle;
            if (wr_en) begin
                commit     = 1'b1;
                commit_cfg = wr_cfg;
            end else if (state_q == StPend) begin
                commit = 1'b1;
            end
        end else if (wr_en) begin
            state_d  = StPend;
            shadow_d = wr_cfg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Scan        <= 2'b00;
            blink_cnt_q <= '0;
            upd_done    <= 1'b0;
            Hexs        <= 16'h0000;
            point       <= 4'h0;
            blank_q     <= BLANK_RST;
            blink_q     <= 4'h0;
            lzs_q       <= 1'b0;
        end else begin
            upd_done <= commit;
            if (tick) begin
                Scan <= Scan + 2'd1;
            end
            if (frame_end) begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            if (commit) begin
                Hexs    <= commit_cfg.data;
                point   <= commit_cfg.point;
                blank_q <= commit_cfg.blank;
                blink_q <= commit_cfg.blink;
                lzs_q   <= commit_cfg.lzs;
            end
        end
    end

    assign busy  = (state_q == StPend);
    assign phase = blink_cnt_q[BLINK_W-1];
    assign LES   = blank_q | (blink_q & {4{phase}}) | lz_mask(Hexs, lzs_q);
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a small divider and blink counter.
module tb_disp_scan_ctrl;
    localparam int DIV_W   = 2;
    localparam int BLINK_W = 2;
    localparam int SLOT    = 1 << DIV_W;
    localparam int FRAME   = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_point = '0, wr_blank = '0, wr_blink = '0;
    logic        wr_lzs = 1'b0;
    logic        busy, upd_done;
    logic [1:0]  Scan;
    logic [15:0] Hexs;
    logic [3:0]  point, LES;

    int total = 0;
    int bad   = 0;

    disp_scan_ctrl #(
        .DIV_W  (DIV_W),
        .BLINK_W(BLINK_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_point(wr_point),
        .wr_blank(wr_blank),
        .wr_blink(wr_blink),
        .wr_lzs  (wr_lzs),
        .busy    (busy),
        .upd_done(upd_done),
        .Scan    (Scan),
        .Hexs    (Hexs),
        .point   (point),
        .LES     (LES)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edge count since reset, a pending write, the visible settings.
    int          edges, frames;
    bit          pend, m_upd;
    logic [15:0] p_data, a_data;
    logic [3:0]  p_point, p_blank, p_blink, a_point, a_blank, a_blink;
    logic        p_lzs, a_lzs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0; frames = 0; pend = 0; m_upd = 0;
            a_data = 0; a_point = 0; a_blank = 4'hF; a_blink = 0; a_lzs = 0;
            p_data = 0; p_point = 0; p_blank = 0; p_blink = 0; p_lzs = 0;
        end else begin
            m_upd = 0;
            if (edges % FRAME == FRAME - 1) begin
                if (wr_en) begin
                    a_data = wr_data; a_point = wr_point; a_blank = wr_blank;
                    a_blink = wr_blink; a_lzs = wr_lzs; m_upd = 1;
                end else if (pend) begin
                    a_data = p_data; a_point = p_point; a_blank = p_blank;
                    a_blink = p_blink; a_lzs = p_lzs; m_upd = 1;
                end
                pend = 0;
                frames++;
            end else if (wr_en) begin
                pend = 1;
                p_data = wr_data; p_point = wr_point; p_blank = wr_blank;
                p_blink = wr_blink; p_lzs = wr_lzs;
            end
            edges++;
        end
    end

    function automatic logic [3:0] model_les();
        logic [3:0] l;
        bit ph;
        ph = ((frames % (1 << BLINK_W)) >= (1 << (BLINK_W - 1)));
        l  = a_blank | (ph ? a_blink : 4'h0);
        for (int i = 1; i < 4; i++) begin
            if (a_lzs && ((a_data >> (4 * i)) == 0)) l[i] = 1'b1;
        end
        return l;
    endfunction

    always @(negedge clk) begin
        chk("scan", 32'(Scan), 32'((edges / SLOT) % 4));
        chk("hexs", 32'(Hexs), 32'(a_data));
        chk("point", 32'(point), 32'(a_point));
        chk("les", 32'(LES), 32'(model_les()));
        chk("busy", 32'(busy), 32'(pend));
        chk("upd_done", 32'(upd_done), 32'(m_upd));
    end

    // Leave the bench positioned #2 after the edge that brings edges%FRAME to k.
    task automatic align(input int k);
        do begin
            @(posedge clk); #2;
        end while (edges % FRAME != k);
    endtask

    task automatic wr(input int k, input logic [15:0] d, input logic [3:0] bl,
                      input logic [3:0] bk, input logic lz);
        align(k);
        wr_data = d; wr_point = d[3:0]; wr_blank = bl; wr_blink = bk; wr_lzs = lz;
        wr_en = 1'b1;
        @(posedge clk); #2;
        wr_en = 1'b0;
    endtask

    task automatic count_upd(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (upd_done) n++;
        end
    endtask

    int n, ones;

    initial begin
        #7;
        chk("rst_scan", 32'(Scan), 32'h0);
        chk("rst_les", 32'(LES), 32'hF);
        chk("rst_hexs", 32'(Hexs), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        align(4);  chk("seq1", 32'(Scan), 32'd1);
        align(8);  chk("seq2", 32'(Scan), 32'd2);
        align(12); chk("seq3", 32'(Scan), 32'd3);
        align(0);  chk("seq0", 32'(Scan), 32'd0);
        chk("idle_les", 32'(LES), 32'hF);

        wr(5, 16'h12A4, 4'h0, 4'h0, 1'b0);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_hold", 32'(Hexs), 32'h0);
        count_upd(20, n);
        chk("one_pulse", 32'(n), 32'd1);
        chk("commit_hexs", 32'(Hexs), 32'h12A4);
        chk("commit_les", 32'(LES), 32'h0);
        chk("commit_busy", 32'(busy), 32'h0);

        wr(3, 16'h1111, 4'h0, 4'h0, 1'b0);
        wr(7, 16'h2222, 4'h0, 4'h0, 1'b0);
        chk("lww_busy", 32'(busy), 32'h1);
        chk("lww_hold", 32'(Hexs), 32'h12A4);
        count_upd(16, n);
        chk("lww_pulse", 32'(n), 32'd1);
        chk("lww_hexs", 32'(Hexs), 32'h2222);

        wr(15, 16'h3333, 4'h0, 4'h0, 1'b0);
        chk("fe_busy", 32'(busy), 32'h0);
        chk("fe_hexs", 32'(Hexs), 32'h3333);
        chk("fe_upd", 32'(upd_done), 32'h1);

        wr(15, 16'h0050, 4'h0, 4'h0, 1'b1);
        chk("lzs_0050", 32'(LES), 32'hC);
        wr(15, 16'h0000, 4'h0, 4'h0, 1'b1);
        chk("lzs_0000", 32'(LES), 32'hE);

        wr(15, 16'h1234, 4'h0, 4'h1, 1'b0);
        ones = 0;
        for (int f = 0; f < 8; f++) begin
            align(2);
            if (LES[0]) ones++;
            chk("blink_upper", 32'(LES[3:1]), 32'h0);
        end
        chk("blink_ones", 32'(ones), 32'd4);

        wr(3, 16'hBEEF, 4'h0, 4'h0, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_les", 32'(LES), 32'hF);
        chk("arst_hexs", 32'(Hexs), 32'h0);
        chk("arst_scan", 32'(Scan), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        count_upd(40, n);
        chk("post_rst_pulse", 32'(n), 32'd0);
        chk("post_rst_hexs", 32'(Hexs), 32'h0);

        @(posedge clk); #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
